mplc_fetch_unit: RTL and testbench

//   Instruction fetch/sequencer for one MPLC core. Drives the program memory address
//   and samples the combinational read data in the same cycle.

---
 rtl/mplc_fetch_unit_pkg.sv | 45 ++++
 rtl/mplc_fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_mplc_fetch_unit.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mplc_fetch_unit_pkg.sv
// Shared MPLC instruction-list definitions: opcodes, addressing modes, field slices
// and fetch sequencer state encodings.
package mplc_fetch_unit_pkg;

  localparam int unsigned OPC_MSB  = 17;
  localparam int unsigned OPC_LSB  = 14;
  localparam int unsigned MODE_MSB = 13;
  localparam int unsigned MODE_LSB = 12;
  localparam int unsigned OPR_MSB  = 11;

  typedef enum logic [3:0] {
    I_NOP  = 4'h0,
    I_LD   = 4'h1,
    I_LDN  = 4'h2,
    I_ST   = 4'h3,
    I_STN  = 4'h4,
    I_AND  = 4'h5,
    I_ANDN = 4'h6,
    I_OR   = 4'h7,
    I_ORN  = 4'h8,
    I_XOR  = 4'h9,
    I_NOT  = 4'hA,
    I_JMP  = 4'hC,
    I_JMPC = 4'hD
  } opcode_e;

  typedef enum logic [1:0] {
    M_DIRECT   = 2'd0,
    M_IMM      = 2'd1,
    M_INDIRECT = 2'd2,
    M_RSVD     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    FETCH_ST_IDLE      = 2'd0,
    FETCH_ST_RUN       = 2'd1,
    FETCH_ST_WAIT_COND = 2'd2
  } fetch_state_e;

  function automatic logic [17:0] mk_instr(input opcode_e op, input mode_e md,
                                           input logic [11:0] opr);
    return {op, md, opr};
  endfunction

endpackage

// File: rtl/mplc_fetch_unit.sv
// MPLC instruction fetch/sequencer: resolves JMP/JMPC, issues IR over valid/ready,
// marks scan boundaries. Optional instruction watchdog via MPLC_FETCH_WATCHDOG_EN.
module mplc_fetch_unit
  import mplc_fetch_unit_pkg::*;
#(
  parameter int unsigned    DW        = 18,
  parameter int unsigned    AW        = 12,
  parameter logic [AW-1:0]  END_ADDR  = 12'hFFF,
  parameter int unsigned    SCW       = 16,
  parameter int unsigned    WDT_LIMIT = 4095
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           EN,
  output logic [AW-1:0]  A,
  input  logic [DW-1:0]  DQ,
  output logic [DW-1:0]  IR,
  output logic [AW-1:0]  IR_PC,
  output logic           IR_VALID,
  input  logic           IR_READY,
  input  logic           COND_VALID,
  input  logic           COND,
  output logic           SCAN_DONE,
  output logic [SCW-1:0] SCAN_CNT,
  output logic           WDT_TRIP
);

  fetch_state_e   state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [DW-1:0]  ir_q, ir_d;
  logic [AW-1:0]  ir_pc_q, ir_pc_d;
  logic           ir_valid_q, ir_valid_d;
  logic           scan_done_q, scan_done_d;
  logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
  logic [AW-1:0]  jmpc_tgt_q, jmpc_tgt_d;

  logic [3:0]     opc;
  logic [AW-1:0]  operand;
  logic           slot_free;
  logic           consume;
  logic           end_scan;
  logic           wdt_trip;

`ifdef MPLC_FETCH_WATCHDOG_EN
  localparam int unsigned WCW = $clog2(WDT_LIMIT + 1);
  logic [WCW-1:0] wdt_cnt_q, wdt_cnt_d;
  logic           wdt_trip_q, wdt_trip_d;
  assign wdt_trip = wdt_trip_q;
`else
  assign wdt_trip = 1'b0;
`endif

  assign opc       = DQ[OPC_MSB:OPC_LSB];
  assign operand   = AW'(DQ[OPR_MSB:0]);
  assign slot_free = !ir_valid_q || IR_READY;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ir_pc_d     = ir_pc_q;
    ir_valid_d  = ir_valid_q && !IR_READY;
    scan_done_d = 1'b0;
    scan_cnt_d  = scan_cnt_q;
    jmpc_tgt_d  = jmpc_tgt_q;
    consume     = 1'b0;
    end_scan    = 1'b0;

    unique case (state_q)
      FETCH_ST_IDLE: begin
        if (EN && !wdt_trip) state_d = FETCH_ST_RUN;
      end
      FETCH_ST_RUN: begin
        if (slot_free) begin
          consume = 1'b1;
          if (opc == I_JMP) begin
            if (operand == END_ADDR) end_scan = 1'b1;
            else                     pc_d     = operand;
          end else begin
            ir_d       = DQ;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            if (opc == I_JMPC) begin
              jmpc_tgt_d = operand;
              state_d    = FETCH_ST_WAIT_COND;
            end else begin
              pc_d = pc_q + AW'(1);
            end
          end
        end
      end
      FETCH_ST_WAIT_COND: begin
        if (COND_VALID) begin
          state_d = FETCH_ST_RUN;
          if (!COND)                        pc_d     = pc_q + AW'(1);
          else if (jmpc_tgt_q == END_ADDR)  end_scan = 1'b1;
          else                              pc_d     = jmpc_tgt_q;
        end
      end
      default: state_d = FETCH_ST_IDLE;
    endcase

    // Scan end is shared by JMP END_ADDR and a taken JMPC END_ADDR; EN is only honoured here.
    if (end_scan) begin
      pc_d        = '0;
      scan_done_d = 1'b1;
      scan_cnt_d  = scan_cnt_q + SCW'(1);
      state_d     = EN ? FETCH_ST_RUN : FETCH_ST_IDLE;
    end

`ifdef MPLC_FETCH_WATCHDOG_EN
    wdt_cnt_d  = wdt_cnt_q;
    wdt_trip_d = wdt_trip_q;
    if (end_scan) begin
      wdt_cnt_d = '0;
    end else if (consume) begin
      wdt_cnt_d = wdt_cnt_q + WCW'(1);
      if (wdt_cnt_d == WCW'(WDT_LIMIT)) wdt_trip_d = 1'b1;
    end
    if (wdt_trip_d) state_d = FETCH_ST_IDLE;
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= FETCH_ST_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      ir_pc_q     <= '0;
      ir_valid_q  <= 1'b0;
      scan_done_q <= 1'b0;
      scan_cnt_q  <= '0;
      jmpc_tgt_q  <= '0;
`ifdef MPLC_FETCH_WATCHDOG_EN
      wdt_cnt_q   <= '0;
      wdt_trip_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      ir_pc_q     <= ir_pc_d;
      ir_valid_q  <= ir_valid_d;
      scan_done_q <= scan_done_d;
      scan_cnt_q  <= scan_cnt_d;
      jmpc_tgt_q  <= jmpc_tgt_d;
`ifdef MPLC_FETCH_WATCHDOG_EN
      wdt_cnt_q   <= wdt_cnt_d;
      wdt_trip_q  <= wdt_trip_d;
`endif
    end
  end

  assign A         = pc_q;
  assign IR        = ir_q;
  assign IR_PC     = ir_pc_q;
  assign IR_VALID  = ir_valid_q;
  assign SCAN_DONE = scan_done_q;
  assign SCAN_CNT  = scan_cnt_q;
  assign WDT_TRIP  = wdt_trip;

endmodule

// File: tb/tb_mplc_fetch_unit.sv
// Directed bench for mplc_fetch_unit: sequencing, backpressure, jumps, scan end,
// reset and (when MPLC_FETCH_WATCHDOG_EN is defined) the watchdog.
module tb_mplc_fetch_unit;
  import mplc_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, en, ir_ready, cond_valid, cond;
  logic [11:0] a, ir_pc;
  logic [17:0] dq, ir;
  logic        ir_valid, scan_done, wdt_trip;
  logic [15:0] scan_cnt;
  logic [17:0] mem [0:4095];

  int tests  = 0;
  int failed = 0;

`ifdef MPLC_FETCH_WATCHDOG_EN
  localparam logic WDT_ON = 1'b1;
`else
  localparam logic WDT_ON = 1'b0;
`endif

  mplc_fetch_unit #(
    .DW(18), .AW(12), .END_ADDR(12'hFFF), .SCW(16), .WDT_LIMIT(8)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .EN(en), .A(a), .DQ(dq), .IR(ir), .IR_PC(ir_pc),
    .IR_VALID(ir_valid), .IR_READY(ir_ready), .COND_VALID(cond_valid), .COND(cond),
    .SCAN_DONE(scan_done), .SCAN_CNT(scan_cnt), .WDT_TRIP(wdt_trip)
  );

  always #5 clk = ~clk;
  assign dq = mem[a];

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = mk_instr(I_NOP, M_DIRECT, 12'h000);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; ir_ready = 1'b1; cond_valid = 1'b0; cond = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic load_scan4();
    clear_mem();
    mem[0] = mk_instr(I_LD,  M_DIRECT, 12'h000);
    mem[1] = mk_instr(I_OR,  M_DIRECT, 12'h001);
    mem[2] = mk_instr(I_ST,  M_DIRECT, 12'h003);
    mem[3] = mk_instr(I_JMP, M_DIRECT, 12'hFFF);
  endtask

  initial begin
    // Reset values
    clear_mem();
    do_reset();
    check("rst_a", a, 0);
    check("rst_ir", ir, 0);
    check("rst_ir_pc", ir_pc, 0);
    check("rst_ir_valid", ir_valid, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_scan_cnt", scan_cnt, 0);
    check("rst_wdt", wdt_trip, 0);

    // 1) four-word scan with IR_READY high
    load_scan4();
    en = 1'b1;
    step(1);
    check("t1_idle_a", a, 0);
    check("t1_idle_valid", ir_valid, 0);
    step(1);
    check("t1_ir0", ir, mk_instr(I_LD, M_DIRECT, 12'h000));
    check("t1_pc0", ir_pc, 0);
    check("t1_a1", a, 1);
    step(1);
    check("t1_pc1", ir_pc, 1);
    step(1);
    check("t1_pc2", ir_pc, 2);
    check("t1_a3", a, 3);
    step(1);
    check("t1_done", scan_done, 1);
    check("t1_cnt", scan_cnt, 1);
    check("t1_a_wrap", a, 0);
    check("t1_jmp_not_issued", ir_valid, 0);
    step(1);
    check("t1_done_pulse", scan_done, 0);
    check("t1_refetch_pc", ir_pc, 0);
    check("t1_refetch_valid", ir_valid, 1);

    // 2) backpressure for three cycles
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("t2_hold_pc", ir_pc, 0);
      check("t2_hold_ir", ir, mk_instr(I_LD, M_DIRECT, 12'h000));
      check("t2_hold_a", a, 1);
      check("t2_hold_valid", ir_valid, 1);
    end
    ir_ready = 1'b1;
    step(1);
    check("t2_resume_pc", ir_pc, 1);
    check("t2_resume_a", a, 2);
    step(1);
    check("t2_next_pc", ir_pc, 2);
    step(1);
    check("t2_scan_cnt", scan_cnt, 2);
    check("t2_scan_done", scan_done, 1);

    // 3) JMPC taken then not taken; COND_VALID in the issue cycle is ignored
    for (int c = 0; c < 2; c++) begin
      clear_mem();
      for (int i = 0; i < 4; i++) mem[i] = mk_instr(I_LD, M_DIRECT, 12'h000);
      mem[4]  = mk_instr(I_JMPC, M_DIRECT, 12'h00A);
      mem[5]  = mk_instr(I_LD, M_DIRECT, 12'h005);
      mem[10] = mk_instr(I_LD, M_DIRECT, 12'h00A);
      do_reset();
      en = 1'b1;
      step(5);
      cond_valid = 1'b1; cond = 1'b1;
      step(1);
      check("t3_jmpc_pc", ir_pc, 4);
      check("t3_jmpc_ir", ir, mk_instr(I_JMPC, M_DIRECT, 12'h00A));
      check("t3_jmpc_a", a, 4);
      cond_valid = 1'b0;
      step(1);
      check("t3_wait_a", a, 4);
      check("t3_wait_valid", ir_valid, 0);
      cond_valid = 1'b1; cond = (c == 0);
      step(1);
      cond_valid = 1'b0;
      check("t3_target_a", a, (c == 0) ? 32'h00A : 32'h005);
      step(1);
      check("t3_target_ir_pc", ir_pc, (c == 0) ? 32'h00A : 32'h005);
      check("t3_target_valid", ir_valid, 1);
    end

    // 4) JMP 020 never issued; PC wraps FFF -> 0 without SCAN_DONE
    clear_mem();
    mem[0]      = mk_instr(I_LD,  M_DIRECT, 12'h000);
    mem[1]      = mk_instr(I_JMP, M_DIRECT, 12'h020);
    mem[12'h20] = mk_instr(I_ST,  M_DIRECT, 12'h020);
    mem[12'h21] = mk_instr(I_JMP, M_DIRECT, 12'hFFE);
    mem[12'hFFE] = mk_instr(I_LD, M_DIRECT, 12'h0FE);
    mem[12'hFFF] = mk_instr(I_OR, M_DIRECT, 12'h0FF);
    do_reset();
    en = 1'b1;
    step(2);
    check("t4_pc0", ir_pc, 0);
    step(1);
    check("t4_bubble", ir_valid, 0);
    check("t4_a_target", a, 12'h020);
    step(1);
    check("t4_ir_pc", ir_pc, 12'h020);
    check("t4_ir", ir, mk_instr(I_ST, M_DIRECT, 12'h020));
    step(2);
    check("t4_pc_ffe", ir_pc, 12'hFFE);
    step(1);
    check("t4_pc_fff", ir_pc, 12'hFFF);
    check("t4_a_wrap", a, 0);
    check("t4_wrap_no_done", scan_done, 0);

    // 5a) EN dropped mid-scan: scan completes then idles
    load_scan4();
    do_reset();
    en = 1'b1;
    step(3);
    check("t5_a2", a, 2);
    en = 1'b0;
    step(1);
    check("t5_pc2_issued", ir_pc, 2);
    step(1);
    check("t5_done", scan_done, 1);
    check("t5_cnt", scan_cnt, 1);
    check("t5_a0", a, 0);
    check("t5_valid0", ir_valid, 0);
    step(1);
    check("t5_idle_a", a, 0);
    check("t5_idle_done", scan_done, 0);
    step(2);
    check("t5_idle_valid", ir_valid, 0);
    check("t5_idle_state", dut.state_q, FETCH_ST_IDLE);

    // 5b) JMPC to END_ADDR taken ends scan; reset mid-WAIT_COND drops everything
    clear_mem();
    mem[0] = mk_instr(I_LD,   M_DIRECT, 12'h000);
    mem[1] = mk_instr(I_JMPC, M_DIRECT, 12'hFFF);
    do_reset();
    en = 1'b1;
    step(3);
    check("t5b_wait_a", a, 1);
    cond_valid = 1'b1; cond = 1'b1;
    step(1);
    cond_valid = 1'b0;
    check("t5b_end_a", a, 0);
    check("t5b_end_done", scan_done, 1);
    check("t5b_end_cnt", scan_cnt, 1);
    step(2);
    check("t5b_jmpc_pc", ir_pc, 1);
    check("t5b_jmpc_valid", ir_valid, 1);
    rst_n = 1'b0; en = 1'b0;
    step(1);
    check("t5b_rst_a", a, 0);
    check("t5b_rst_ir", ir, 0);
    check("t5b_rst_ir_pc", ir_pc, 0);
    check("t5b_rst_valid", ir_valid, 0);
    check("t5b_rst_cnt", scan_cnt, 0);
    check("t5b_rst_done", scan_done, 0);
    rst_n = 1'b1; cond_valid = 1'b1; cond = 1'b1;
    step(1);
    cond_valid = 1'b0;
    check("t5b_no_pending_a", a, 0);
    check("t5b_no_pending_cnt", scan_cnt, 0);
    check("t5b_no_pending_state", dut.state_q, FETCH_ST_IDLE);

    // 6) JMP 000 loop against an 8-instruction watchdog
    clear_mem();
    mem[0] = mk_instr(I_JMP, M_DIRECT, 12'h000);
    do_reset();
    en = 1'b1;
    step(8);
    check("t6_before_limit", wdt_trip, 0);
    step(1);
    check("t6_trip", wdt_trip, WDT_ON);
    check("t6_state", dut.state_q, WDT_ON ? FETCH_ST_IDLE : FETCH_ST_RUN);
    step(4);
    check("t6_sticky", wdt_trip, WDT_ON);
    check("t6_state_sticky", dut.state_q, WDT_ON ? FETCH_ST_IDLE : FETCH_ST_RUN);
    check("t6_no_issue", ir_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
